// File: rtl/mux_sched_pkg.sv
// Shared definitions for the round-robin mux scheduler.
//   sel_width() : select width derived from the requester count
//   state_t     : scheduler FSM states (IDLE arbitrates, BUSY holds a grant)
//   BEAT_W      : width of the per-grant beat counter
package mux_sched_pkg;

  localparam int unsigned BEAT_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // A select port is never narrower than one bit, even for two requesters.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority encoder.
// Searches req upward starting at ptr, wrapping N-1 -> 0; the first set bit wins.
//   req   [N-1:0] in  request vector
//   ptr   [W-1:0] in  search start index (always < N)
//   found         out at least one request set
//   idx   [W-1:0] out winning index (0 when nothing is found)
module rr_pick #(
  parameter int unsigned N = 31,
  parameter int unsigned W = 5
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  int unsigned c;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    c     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      c = 32'(ptr) + i;
      if (c >= N) c = c - N;
      if (!found && req[W'(c)]) begin
        found = 1'b1;
        idx   = W'(c);
      end
    end
  end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler driving the select of a NUM_REQ:1 mux.
// A winner is picked in IDLE, registered onto sel/gnt, and held in BUSY for up
// to MAX_BEATS beats (beat = sel_vld & out_ready) or until its request drops.
// Optional feature macro: ARB_LOCK_EN (lock[sel] extends a burst past MAX_BEATS).
//   clk        in   rising-edge clock
//   rst_n      in   async active-low reset
//   req        in   [NUM_REQ-1:0] level request per requester
//   lock       in   [NUM_REQ-1:0] burst-extend per requester (ARB_LOCK_EN only)
//   out_ready  in   downstream accepts current mux output
//   sel        out  [SEL_W-1:0] registered mux select
//   sel_vld    out  sel is valid
//   gnt        out  [NUM_REQ-1:0] one-hot grant, zero when not valid
//   gnt_done   out  one-cycle pulse in the cycle after a grant ends
module mux_rr_scheduler
  import mux_sched_pkg::*;
#(
  parameter  int unsigned NUM_REQ   = 31,
  parameter  int unsigned MAX_BEATS = 4,
  localparam int unsigned SEL_W     = sel_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] lock,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_vld,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_done
);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic               vld_q, vld_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               done_q, done_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;

  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;
  logic               hold_lock;

`ifdef ARB_LOCK_EN
  assign hold_lock = lock[sel_q];
`else
  logic unused_lock;
  assign hold_lock   = 1'b0;
  assign unused_lock = ^lock;
`endif

  rr_pick #(
    .N (NUM_REQ),
    .W (SEL_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    vld_d   = vld_q;
    gnt_d   = gnt_q;
    done_d  = 1'b0;
    beat_d  = beat_q;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d         = BUSY;
          sel_d           = pick_idx;
          vld_d           = 1'b1;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          beat_d          = '0;
        end
      end
      BUSY: begin
        // Request drop takes priority and swallows any beat in the same cycle.
        if (!req[sel_q]) begin
          state_d = IDLE;
        end else if (out_ready) begin
          if (beat_q == BEAT_W'(MAX_BEATS - 1)) begin
            if (hold_lock) beat_d = '0;
            else           state_d = IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
        if (state_d == IDLE) begin
          vld_d  = 1'b0;
          gnt_d  = '0;
          beat_d = '0;
          done_d = 1'b1;
          ptr_d  = (sel_q == SEL_W'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      vld_q   <= 1'b0;
      gnt_q   <= '0;
      done_q  <= 1'b0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      vld_q   <= vld_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      beat_q  <= beat_d;
    end
  end

  assign sel      = sel_q;
  assign sel_vld  = vld_q;
  assign gnt      = gnt_q;
  assign gnt_done = done_q;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Directed bench for mux_rr_scheduler: expected grants (requester, beat count)
// are queued as stimulus is applied and checked as each grant completes.
module tb_mux_rr_scheduler;

  localparam int unsigned NREQ = 31;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] lock;
  logic            out_ready;
  logic [4:0]      sel;
  logic            sel_vld;
  logic [NREQ-1:0] gnt;
  logic            gnt_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned sel;
    int unsigned beats;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mux_rr_scheduler #(
    .NUM_REQ   (31),
    .MAX_BEATS (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .lock      (lock),
    .out_ready (out_ready),
    .sel       (sel),
    .sel_vld   (sel_vld),
    .gnt       (gnt),
    .gnt_done  (gnt_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic logic [NREQ-1:0] bit_of(input int unsigned i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Waits for the next grant, checks it against the scoreboard head, optionally
  // stalls out_ready for `stall` cycles, then counts beats to the grant end.
  // Returns on the negedge where gnt_done is expected high.
  task automatic grant_chk(input int stall);
    exp_t e;
    int   n;
    int   beats;
    bit   ok;
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sel_vld && n < 50);
    check("grant_seen", {31'd0, sel_vld}, 1);
    check("gnt_done_low", {31'd0, gnt_done}, 0);
    check("sel", {27'd0, sel}, e.sel);
    check("gnt_onehot", {1'b0, gnt}, {1'b0, bit_of(e.sel)});
    if (stall > 0) begin
      out_ready = 1'b0;
      ok = 1'b1;
      repeat (stall) begin
        @(negedge clk);
        if (!(sel_vld && sel == 5'(e.sel))) ok = 1'b0;
      end
      check("stall_hold", {31'd0, ok}, 1);
      out_ready = 1'b1;
    end
    beats = 0;
    n = 0;
    while (sel_vld && n < 200) begin
      if (out_ready) beats++;
      @(negedge clk);
      n++;
    end
    check("beats", beats, e.beats);
    check("end_gnt_zero", {1'b0, gnt}, 0);
    check("gnt_done_pulse", {31'd0, gnt_done}, 1);
  endtask

  initial begin
    int n;

    // Reset with all requests high.
    rst_n     = 1'b0;
    req       = '1;
    lock      = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_vld", {31'd0, sel_vld}, 0);
    check("rst_gnt", {1'b0, gnt}, 0);
    check("rst_sel", {27'd0, sel}, 0);
    check("rst_done", {31'd0, gnt_done}, 0);
    rst_n = 1'b1;
    sb.push_back('{0, 4});
    grant_chk(0);

    // Rotation 3 -> 7 -> 30 -> 3.
    req = bit_of(3) | bit_of(7) | bit_of(30);
    sb.push_back('{3, 4});
    sb.push_back('{7, 4});
    sb.push_back('{30, 4});
    sb.push_back('{3, 4});
    repeat (4) grant_chk(0);

    // Wrap: 29 leaves ptr at 30, then {0,30} -> 30 then 0.
    req = bit_of(29);
    sb.push_back('{29, 4});
    grant_chk(0);
    req = bit_of(0) | bit_of(30);
    sb.push_back('{30, 4});
    sb.push_back('{0, 4});
    grant_chk(0);
    grant_chk(0);

    // Stall: a long out_ready-low period must not consume beats.
    req = bit_of(5);
    sb.push_back('{5, 4});
    grant_chk(10);

    // Drop: ptr=6 wraps to 5; drop req[5] after two beats.
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sel_vld && n < 50);
    check("drop_grant_sel", {27'd0, sel}, 5);
    repeat (2) @(negedge clk);
    req = '0;
    @(negedge clk);
    check("drop_vld", {31'd0, sel_vld}, 0);
    check("drop_done", {31'd0, gnt_done}, 1);
    check("drop_gnt", {1'b0, gnt}, 0);
    req = bit_of(4) | bit_of(6);
    sb.push_back('{6, 4});
    grant_chk(0);
    req = '0;

    // No request: stays idle.
    repeat (5) @(negedge clk);
    check("idle_vld", {31'd0, sel_vld}, 0);
    check("idle_gnt", {1'b0, gnt}, 0);

    // Lock with a fresh pointer.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req  = bit_of(2) | bit_of(9);
    lock = bit_of(2);
`ifdef ARB_LOCK_EN
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sel_vld && n < 50);
    check("lock_sel", {27'd0, sel}, 2);
    repeat (8) @(negedge clk);
    check("lock_hold", {31'd0, (sel_vld && sel == 5'd2)}, 1);
    lock = '0;
    n = 0;
    while (sel_vld && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("lock_release_beats", n, 4);
    check("lock_release_done", {31'd0, gnt_done}, 1);
    sb.push_back('{9, 4});
    grant_chk(0);
`else
    sb.push_back('{2, 4});
    sb.push_back('{9, 4});
    grant_chk(0);
    grant_chk(0);
`endif
    req  = '0;
    lock = '0;

    // Reset mid-burst at beat 2 of grant 12.
    req = bit_of(12);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sel_vld && n < 50);
    check("midrst_sel", {27'd0, sel}, 12);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_vld", {31'd0, sel_vld}, 0);
    check("midrst_gnt", {1'b0, gnt}, 0);
    check("midrst_sel0", {27'd0, sel}, 0);
    check("midrst_done", {31'd0, gnt_done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    req = bit_of(12) | bit_of(13);
    sb.push_back('{12, 4});
    grant_chk(0);
    req = '0;
    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
